// File: rtl/ir_line_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ir_pkg
// Description : Shared definitions for the IR line-scan block: channel count
//               and indices, scan FSM state encoding, clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ir_pkg;

  // Five receiver channels, bit 4 is the leftmost sensor
  localparam int N_CH  = 5;
  localparam int CH_L  = 4;
  localparam int CH_LC = 3;
  localparam int CH_C  = 2;
  localparam int CH_RC = 1;
  localparam int CH_R  = 0;

  // Scan sequence: dark sample, lit sample, evaluate, idle gap until the period ends
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DARK = 3'd1,
    LIT  = 3'd2,
    EVAL = 3'd3,
    GAP  = 3'd4
  } ir_state_e;

  // Number of bits needed to represent values 0..value-1
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_line_scan_sync2.sv
`default_nettype none
// ============================================================================
// Module      : ir_sync2
// Description : Parameterised-width two-flop synchronizer with asynchronous
//               active-low reset. Output lags the input by two clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give a metastability settling window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/ir_line_scan.sv
`default_nettype none
// ============================================================================
// Module      : ir_line_scan
// Description : Drives the IR emitter of a five-channel line sensor, samples
//               the receivers once dark and once lit each scan, and publishes
//               ambient-rejected line flags plus an ambient-fault vector.
//               Optional macro IR_DEBOUNCE_EN adds a per-channel debounce that
//               only flips a line flag after DEB_N consecutive differing scans.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_line_scan
  import ir_pkg::*;
#(
  parameter int SETTLE_CYC = 2000,
  parameter int PERIOD_CYC = 10000
`ifdef IR_DEBOUNCE_EN
  ,
  parameter int DEB_N      = 3
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N_CH-1:0] rx_i,
  output logic            emit_en,
  output logic [N_CH-1:0] line_o,
  output logic [N_CH-1:0] ambient_o,
  output logic            scan_valid
);

  localparam int PW = clog2(PERIOD_CYC);

  // Phase counter values at which each phase ends
  localparam logic [PW-1:0] C_DARK_END = PW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] C_LIT_END  = PW'(2 * SETTLE_CYC - 1);
  localparam logic [PW-1:0] C_LAST     = PW'(PERIOD_CYC - 1);

  ir_state_e       state_q;
  logic [PW-1:0]   pcnt_q;
  logic            emit_en_q;
  logic [N_CH-1:0] dark_q;
  logic [N_CH-1:0] lit_q;
  logic [N_CH-1:0] line_q;
  logic [N_CH-1:0] ambient_q;
  logic            scan_valid_q;
  logic [N_CH-1:0] rx_sync;
  logic [N_CH-1:0] line_cand;

`ifdef IR_DEBOUNCE_EN
  localparam int DW = clog2(DEB_N + 1);
  localparam logic [DW-1:0] C_DEB_LAST = DW'(DEB_N - 1);

  logic [DW-1:0] deb_cnt_q [N_CH];
`endif

  // Receiver comparators are asynchronous to clk
  ir_sync2 #(
    .WIDTH (N_CH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_i),
    .q_o   (rx_sync)
  );

  // A channel sees the line when it receives only with the emitter lit
  assign line_cand = lit_q & ~dark_q;

  // Scan sequencer: phase counter, emitter drive, samples and published results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pcnt_q       <= '0;
      emit_en_q    <= 1'b0;
      dark_q       <= '0;
      lit_q        <= '0;
      line_q       <= '0;
      ambient_q    <= '0;
      scan_valid_q <= 1'b0;
`ifdef IR_DEBOUNCE_EN
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= '0;
      end
`endif
    end else if (!enable && (state_q != EVAL)) begin
      // Abort: discard partial samples, keep the published flags
      state_q      <= IDLE;
      pcnt_q       <= '0;
      emit_en_q    <= 1'b0;
      dark_q       <= '0;
      lit_q        <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // enable is high here, so a fresh scan starts
          pcnt_q    <= '0;
          emit_en_q <= 1'b0;
          state_q   <= DARK;
        end
        DARK: begin
          pcnt_q <= pcnt_q + PW'(1);
          if (pcnt_q == C_DARK_END) begin
            dark_q    <= rx_sync;
            emit_en_q <= 1'b1;
            state_q   <= LIT;
          end
        end
        LIT: begin
          pcnt_q <= pcnt_q + PW'(1);
          if (pcnt_q == C_LIT_END) begin
            lit_q     <= rx_sync;
            emit_en_q <= 1'b0;
            state_q   <= EVAL;
          end
        end
        EVAL: begin
          // Evaluation always completes, even if enable dropped this cycle
          ambient_q    <= dark_q;
          scan_valid_q <= 1'b1;
          emit_en_q    <= 1'b0;
`ifdef IR_DEBOUNCE_EN
          for (int i = 0; i < N_CH; i++) begin
            if (line_cand[i] != line_q[i]) begin
              if (deb_cnt_q[i] == C_DEB_LAST) begin
                line_q[i]    <= line_cand[i];
                deb_cnt_q[i] <= '0;
              end else begin
                deb_cnt_q[i] <= deb_cnt_q[i] + DW'(1);
              end
            end else begin
              deb_cnt_q[i] <= '0;
            end
          end
`else
          line_q <= line_cand;
`endif
          if (enable) begin
            pcnt_q  <= pcnt_q + PW'(1);
            state_q <= GAP;
          end else begin
            pcnt_q  <= '0;
            state_q <= IDLE;
          end
        end
        GAP: begin
          if (pcnt_q == C_LAST) begin
            pcnt_q  <= '0;
            state_q <= DARK;
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        default: begin
          pcnt_q    <= '0;
          emit_en_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign emit_en    = emit_en_q;
  assign line_o     = line_q;
  assign ambient_o  = ambient_q;
  assign scan_valid = scan_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_line_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_line_scan
// Description : Self-checking bench for ir_line_scan. A scan-offset reference
//               model predicts emitter timing, result pulses and the published
//               flags from the recorded receiver history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_line_scan;

  localparam int S   = 4;
  localparam int P   = 12;
  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [4:0] rx_i;
  logic       emit_en;
  logic [4:0] line_o;
  logic [4:0] ambient_o;
  logic       scan_valid;

  always #5 clk = ~clk;

  ir_line_scan #(
    .SETTLE_CYC (S),
    .PERIOD_CYC (P)
`ifdef IR_DEBOUNCE_EN
    ,
    .DEB_N      (DEB)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rx_i       (rx_i),
    .emit_en    (emit_en),
    .line_o     (line_o),
    .ambient_o  (ambient_o),
    .scan_valid (scan_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus controls
  logic       en_drv   = 1'b0;
  int         mode     = 0;      // 0 random rx, 1 follow emitter, 2 constant
  logic [4:0] lit_pat  = '0;
  logic [4:0] dark_pat = '0;

  // Reference model: offset inside the scan (-1 = idle) and receiver history
  int         cyc      = 0;
  int         m_ofs    = -1;
  int         m_start  = 0;
  logic [4:0] hist [0:65535];
  logic       exp_emit = 1'b0;
  logic       exp_sv   = 1'b0;
  logic [4:0] exp_line = '0;
  logic [4:0] exp_amb  = '0;
  int         streak [5];

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ofs    = -1;
    exp_emit = 1'b0;
    exp_sv   = 1'b0;
    exp_line = '0;
    exp_amb  = '0;
    for (int i = 0; i < 5; i++) streak[i] = 0;
  endtask

  // Advance the model across one clock edge given this cycle's enable
  task automatic model_step(input logic en);
    logic [4:0] dark;
    logic [4:0] lit;
    logic [4:0] cand;
    exp_sv = 1'b0;
    if (m_ofs == 2 * S) begin
      dark    = hist[m_start + S - 3];
      lit     = hist[m_start + 2 * S - 3];
      cand    = lit & ~dark;
      exp_amb = dark;
      exp_sv  = 1'b1;
`ifdef IR_DEBOUNCE_EN
      for (int i = 0; i < 5; i++) begin
        if (cand[i] != exp_line[i]) begin
          streak[i]++;
          if (streak[i] == DEB) begin
            exp_line[i] = cand[i];
            streak[i]   = 0;
          end
        end else begin
          streak[i] = 0;
        end
      end
`else
      exp_line = cand;
`endif
      m_ofs = en ? 2 * S + 1 : -1;
    end else if (!en) begin
      m_ofs = -1;
    end else if (m_ofs == -1) begin
      m_ofs   = 0;
      m_start = cyc + 1;
    end else begin
      m_ofs = (m_ofs + 1) % P;
      if (m_ofs == 0) m_start = cyc + 1;
    end
    exp_emit = (m_ofs >= S) && (m_ofs < 2 * S);
  endtask

  // One clock: drive at negedge, step model at posedge, check just after
  task automatic run_cycle();
    logic [4:0] r;
    @(negedge clk);
    case (mode)
      0:       r = 5'($urandom);
      1:       r = emit_en ? lit_pat : dark_pat;
      default: r = dark_pat;
    endcase
    rx_i      = r;
    enable    = en_drv;
    hist[cyc] = r;
    @(posedge clk);
    model_step(en_drv);
    cyc++;
    #1;
    check_eq("emit_en", {4'b0, emit_en}, {4'b0, exp_emit});
    check_eq("scan_valid", {4'b0, scan_valid}, {4'b0, exp_sv});
    check_eq("line_o", line_o, exp_line);
    check_eq("ambient_o", ambient_o, exp_amb);
  endtask

  task automatic run_scans(input int n);
    int seen  = 0;
    int guard = 0;
    while ((seen < n) && (guard < (n + 2) * P)) begin
      run_cycle();
      guard++;
      if (exp_sv) seen++;
    end
    check_eq("scan_count", 5'(seen), 5'(n));
  endtask

  task automatic run_until(input int ofs);
    int guard = 0;
    while ((m_ofs != ofs) && (guard < 3 * P)) begin
      run_cycle();
      guard++;
    end
    check_eq("reach_phase", {4'b0, (m_ofs == ofs)}, 5'd1);
  endtask

  // Assert reset away from any clock edge and check outputs fall at once
  task automatic async_reset_check(input string tag);
    @(negedge clk);
    #2;
    enable = 1'b0;
    en_drv = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq({tag, "_emit"}, {4'b0, emit_en}, 5'd0);
    check_eq({tag, "_valid"}, {4'b0, scan_valid}, 5'd0);
    check_eq({tag, "_line"}, line_o, 5'd0);
    check_eq({tag, "_amb"}, ambient_o, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    rx_i   = '0;
    model_reset();
    #1;
    check_eq("rst_emit", {4'b0, emit_en}, 5'd0);
    check_eq("rst_valid", {4'b0, scan_valid}, 5'd0);
    check_eq("rst_line", line_o, 5'd0);
    check_eq("rst_amb", ambient_o, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reflective surface: receivers follow the emitter
    en_drv = 1'b1; mode = 1; lit_pat = 5'b11111; dark_pat = 5'b00000;
    run_scans(3);
    check_eq("A_line", line_o, 5'b11111);
    check_eq("A_amb", ambient_o, 5'b00000);

    // Constant ambient light on C
    mode = 2; dark_pat = 5'b00100;
    run_scans(3);
    check_eq("B_line", line_o, 5'b00000);
    check_eq("B_amb", ambient_o, 5'b00100);

    // Reflection on LC and RC, then abort during LIT
    mode = 1; lit_pat = 5'b01010; dark_pat = 5'b00000;
    run_scans(3);
    check_eq("C_line", line_o, 5'b01010);
    run_until(6);
    en_drv = 1'b0;
    repeat (6) run_cycle();
    check_eq("C_hold", line_o, 5'b01010);

    // Re-enable: fresh scan from DARK with new result
    en_drv = 1'b1; lit_pat = 5'b10001;
    run_scans(3);
    check_eq("D_line", line_o, 5'b10001);

    // Drop enable exactly in EVAL: update and pulse still happen
    lit_pat = 5'b00110;
    run_until(2 * S);
    en_drv = 1'b0;
    run_cycle();
    repeat (4) run_cycle();
    en_drv = 1'b1;

    // Randomized receivers, patterns and enable drops
    for (int blk = 0; blk < 60; blk++) begin
      mode     = int'($urandom_range(0, 1));
      lit_pat  = 5'($urandom);
      dark_pat = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00000;
      for (int k = 0; k < 50; k++) begin
        en_drv = ($urandom_range(0, 59) != 0);
        run_cycle();
      end
    end

    // Asynchronous reset in the middle of the lit phase
    en_drv = 1'b1; mode = 1; lit_pat = 5'b11111; dark_pat = 5'b00000;
    run_scans(3);
    run_until(S + 1);
    async_reset_check("rstLIT");

    // Centre channel: two candidate scans then none, then three
    en_drv = 1'b1; mode = 1; dark_pat = 5'b00000; lit_pat = 5'b00100;
    run_scans(2);
`ifdef IR_DEBOUNCE_EN
    check_eq("deb_two", line_o, 5'b00000);
`else
    check_eq("nodeb_two", line_o, 5'b00100);
`endif
    lit_pat = 5'b00000;
    run_scans(1);
    check_eq("deb_clear", line_o, 5'b00000);
    lit_pat = 5'b00100;
    run_scans(2);
`ifdef IR_DEBOUNCE_EN
    check_eq("deb_pre", line_o, 5'b00000);
`else
    check_eq("nodeb_pre", line_o, 5'b00100);
`endif
    run_scans(1);
    check_eq("deb_third", line_o, 5'b00100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
